// File: rtl/uart_receive_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
// Frame state encoding and data width used by the receiver and its interface.
package uart_receive_pkg;

   localparam int unsigned UARTBITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

endpackage

// File: rtl/uart_receive_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
// The slave modport is the receiver; the master modport is the line driver / consumer.
interface uart_receive_if;
   import uart_receive_pkg::*;

   logic                rx;
   logic [UARTBITS-1:0] data;
   logic                valid;
   logic                busy;
   logic                frame_err;

   modport master (output rx, input data, valid, busy, frame_err);
   modport slave  (input rx, output data, valid, busy, frame_err);

endinterface

// File: rtl/uart_receive_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so idle-high and idle-low lines both start quiet.
module uart_receive_sync_2ff #(
   parameter bit ResetVal = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {2{ResetVal}};
      end else begin
         r_sync <= {r_sync[0], i_d};
      end
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver: samples the synchronised line mid-bit, shifts bytes in LSB first,
// strobes valid for a good stop bit and frame_err for a bad one.
module uart_receive
   import uart_receive_pkg::*;
#(
   parameter int unsigned WTIME = 10
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   uart_receive_if.slave  io_uart
);

   localparam int unsigned CntW   = $clog2(WTIME) + 1;
   localparam int unsigned IdxW   = $clog2(UARTBITS);
   localparam logic [CntW-1:0] HalfLoad = CntW'(WTIME / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(WTIME - 1);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(UARTBITS - 1);

   uart_rx_state_t      r_state, w_state;
   logic [CntW-1:0]     r_cnt, w_cnt;
   logic [IdxW-1:0]     r_bit_idx, w_bit_idx;
   logic [UARTBITS-1:0] r_shift, w_shift;
   logic [UARTBITS-1:0] r_data, w_data;
   logic                r_valid, w_valid;
   logic                r_frame_err, w_frame_err;
   logic                w_rx_s;
   logic                w_tick;

   uart_receive_sync_2ff #(
      .ResetVal (1'b1)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (io_uart.rx),
      .o_q     (w_rx_s)
   );

   // Each sample point reloads a full bit period, so the grid never drifts.
   assign w_tick = (r_cnt == '0);

   always_comb begin
      w_state     = r_state;
      w_cnt       = r_cnt;
      w_bit_idx   = r_bit_idx;
      w_shift     = r_shift;
      w_data      = r_data;
      w_valid     = 1'b0;
      w_frame_err = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (!w_rx_s) begin
               w_state   = START;
               w_cnt     = HalfLoad;
               w_bit_idx = '0;
            end
         end
         START: begin
            if (w_tick) begin
               if (w_rx_s) begin
                  w_state = IDLE;
               end else begin
                  w_state = DATA;
                  w_cnt   = FullLoad;
               end
            end else begin
               w_cnt = r_cnt - CntW'(1);
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift = {w_rx_s, r_shift[UARTBITS-1:1]};
               w_cnt   = FullLoad;
               if (r_bit_idx == LastIdx) begin
                  w_state = STOP;
               end else begin
                  w_bit_idx = r_bit_idx + IdxW'(1);
               end
            end else begin
               w_cnt = r_cnt - CntW'(1);
            end
         end
         STOP: begin
            if (w_tick) begin
               if (w_rx_s) begin
                  w_data  = r_shift;
                  w_valid = 1'b1;
                  w_state = IDLE;
               end else begin
                  w_frame_err = 1'b1;
                  w_state     = BREAK;
               end
            end else begin
               w_cnt = r_cnt - CntW'(1);
            end
         end
         BREAK: begin
            // A held-low line must not look like a fresh start bit.
            if (w_rx_s) begin
               w_state = IDLE;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         r_bit_idx   <= w_bit_idx;
         r_shift     <= w_shift;
         r_data      <= w_data;
         r_valid     <= w_valid;
         r_frame_err <= w_frame_err;
      end
   end

   assign io_uart.data      = r_data;
   assign io_uart.valid     = r_valid;
   assign io_uart.frame_err = r_frame_err;
   assign io_uart.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive: good frames, false start, bad stop bit with held break,
// back-to-back frames, reset mid-frame and a 256-byte serial sweep.
module tb_uart_receive;

   localparam int WT = 10;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;

   uart_receive_if u_if ();

   uart_receive #(
      .WTIME (WT)
   ) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_uart (u_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_q[$];
   int         cyc_q[$];
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   int         busy_cyc = 0;

   // Outputs change on the rising edge; observe them on the falling edge.
   always @(negedge clk) begin
      if (u_if.valid) begin
         rx_q.push_back(u_if.data);
         cyc_q.push_back(cyc);
      end
      if (u_if.frame_err) ferr_cnt <= ferr_cnt + 1;
      if (u_if.valid && u_if.frame_err) both_cnt <= both_cnt + 1;
      if (u_if.busy) busy_cyc <= busy_cyc + 1;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Call on a falling edge; leaves the line at the stop-bit level.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         u_if.rx = bits[i];
         repeat (WT) @(negedge clk);
      end
   endtask

   int q0, f0, b0, d;

   initial begin
      rst_n   = 1'b0;
      u_if.rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(u_if.data), 32'h00);
      check("rst_valid", 32'(u_if.valid), 0);
      check("rst_busy", 32'(u_if.busy), 0);
      check("rst_ferr", 32'(u_if.frame_err), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Single good frame
      q0 = rx_q.size(); f0 = ferr_cnt;
      send_frame(8'b0110_0111, 1'b1);
      repeat (5) @(negedge clk);
      check("t1_nvalid", rx_q.size() - q0, 1);
      check("t1_qdata", 32'(rx_q[q0]), 32'h67);
      check("t1_data", 32'(u_if.data), 32'h67);
      check("t1_busy", 32'(u_if.busy), 0);
      check("t1_ferr", ferr_cnt - f0, 0);

      // False start: 3 clocks low
      q0 = rx_q.size(); f0 = ferr_cnt; b0 = busy_cyc;
      u_if.rx = 1'b0;
      repeat (3) @(negedge clk);
      u_if.rx = 1'b1;
      repeat (20) @(negedge clk);
      d = busy_cyc - b0;
      check("fs_busy_len_in_1_to_8", 32'(d >= 1 && d <= WT / 2 + 3), 1);
      check("fs_busy", 32'(u_if.busy), 0);
      check("fs_nvalid", rx_q.size() - q0, 0);
      check("fs_ferr", ferr_cnt - f0, 0);
      check("fs_data", 32'(u_if.data), 32'h67);

      // Bad stop bit, line held low, then recovery
      q0 = rx_q.size(); f0 = ferr_cnt;
      send_frame(8'hA5, 1'b0);
      repeat (30) @(negedge clk);
      check("fe_ferr", ferr_cnt - f0, 1);
      check("fe_nvalid", rx_q.size() - q0, 0);
      check("fe_data", 32'(u_if.data), 32'h67);
      check("fe_busy_held", 32'(u_if.busy), 1);
      u_if.rx = 1'b1;
      repeat (5) @(negedge clk);
      check("fe_busy_released", 32'(u_if.busy), 0);
      check("fe_ferr_once", ferr_cnt - f0, 1);
      send_frame(8'h3C, 1'b1);
      repeat (5) @(negedge clk);
      check("fe_next_nvalid", rx_q.size() - q0, 1);
      check("fe_next_data", 32'(u_if.data), 32'h3C);
      check("fe_ferr_total", ferr_cnt - f0, 1);

      // Back-to-back frames with no idle gap
      q0 = rx_q.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      repeat (5) @(negedge clk);
      check("b2b_nvalid", rx_q.size() - q0, 2);
      check("b2b_first", 32'(rx_q[q0]), 32'h00);
      check("b2b_second", 32'(rx_q[q0+1]), 32'hFF);
      check("b2b_spacing", cyc_q[q0+1] - cyc_q[q0], 100);
      check("b2b_data", 32'(u_if.data), 32'hFF);

      // Reset during bit 4; upper nibble of 8'hF0 keeps the line high afterwards
      q0 = rx_q.size(); f0 = ferr_cnt;
      fork
         send_frame(8'hF0, 1'b1);
         begin
            repeat (55) @(negedge clk);
            #2;
            check("mr_busy_before", 32'(u_if.busy), 1);
            rst_n = 1'b0;
            #1;
            check("mr_data", 32'(u_if.data), 32'h00);
            check("mr_valid", 32'(u_if.valid), 0);
            check("mr_busy", 32'(u_if.busy), 0);
            check("mr_ferr", 32'(u_if.frame_err), 0);
            #10;
            rst_n = 1'b1;
         end
      join
      repeat (5) @(negedge clk);
      check("mr_nvalid", rx_q.size() - q0, 0);
      check("mr_nferr", ferr_cnt - f0, 0);
      check("mr_data_after", 32'(u_if.data), 32'h00);
      send_frame(8'h5A, 1'b1);
      repeat (5) @(negedge clk);
      check("mr_next_nvalid", rx_q.size() - q0, 1);
      check("mr_next_data", 32'(u_if.data), 32'h5A);

      // All 256 byte values, back-to-back
      q0 = rx_q.size(); f0 = ferr_cnt;
      for (int i = 0; i < 256; i++) begin
         send_frame(8'(i), 1'b1);
      end
      repeat (5) @(negedge clk);
      check("sweep_nvalid", rx_q.size() - q0, 256);
      for (int i = 0; i < 256; i++) begin
         check($sformatf("sweep_byte_%0d", i), 32'(rx_q[q0+i]), i);
      end
      check("sweep_ferr", ferr_cnt - f0, 0);
      check("valid_and_ferr_overlap", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
